// File: rtl/scan_ctrl.sv
// -----------------------------------------------------------------------------
// scan_ctrl
//
// Scan-test controller for one or more equal-length scan chains. Parallel test
// patterns are accepted over a valid/ready handshake and shifted into the
// chains. A single capture cycle follows. The captured responses are unloaded
// into parallel words. The unload of one response overlaps the load of the
// next pattern. The final pattern of a run is followed by a dedicated unload
// phase.
//
// Parameters
//   NCHAIN     number of parallel scan chains
//   CHAIN_LEN  flops per chain (>= 2)
//   CNT_W      width of the capture counter
//
// Ports
//   CK, RST               clock (rising edge), async active-high reset
//   pat_data/valid/last   pattern input; chain c uses slice [c*CHAIN_LEN +: CHAIN_LEN],
//                         slice bit k maps to chain flop k (flop 0 nearest scan_in)
//   pat_ready             pattern accepted on pat_valid & pat_ready
//   rsp_data/valid        unloaded response, held until rsp_ready
//   rsp_ready             response sink ready
//   scan_en               to CUT: 1 = shift, 0 = capture
//   scan_in / scan_out    serial data into / out of each chain
//   cut_ce                CUT clock enable
//   done                  one-cycle pulse when the final response becomes valid
//   pat_cnt               captures since reset (wraps)
// -----------------------------------------------------------------------------
module scan_ctrl #(
    parameter int NCHAIN    = 1,
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = 16
) (
    input  logic                        CK,
    input  logic                        RST,
    input  logic [NCHAIN*CHAIN_LEN-1:0] pat_data,
    input  logic                        pat_valid,
    input  logic                        pat_last,
    output logic                        pat_ready,
    output logic [NCHAIN*CHAIN_LEN-1:0] rsp_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        scan_en,
    output logic [NCHAIN-1:0]           scan_in,
    input  logic [NCHAIN-1:0]           scan_out,
    output logic                        cut_ce,
    output logic                        done,
    output logic [CNT_W-1:0]            pat_cnt
);

    localparam int            W        = NCHAIN * CHAIN_LEN;
    localparam int            CW       = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPT, UNLOAD} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   bit_sel;
    logic [W-1:0]    ld;
    logic [W-1:0]    rsp;
    logic [W-1:0]    rsp_nxt;
    logic            last_q;
    logic            have_rsp;

    // The chain is shifted MSB first: at count j the slice bit CHAIN_LEN-1-j
    // goes out on scan_in. The bit arriving on scan_out lands in the same
    // position, so the flop order is preserved in both directions.
    assign bit_sel = CNT_LAST - cnt;

    always_comb begin
        scan_in = '0;
        rsp_nxt = rsp;
        for (int c = 0; c < NCHAIN; c++) begin
            for (int k = 0; k < CHAIN_LEN; k++) begin
                if (bit_sel == CW'(k)) begin
                    if (state == SHIFT) begin
                        scan_in[c] = ld[c*CHAIN_LEN + k];
                    end
                    rsp_nxt[c*CHAIN_LEN + k] = scan_out[c];
                end
            end
        end
    end

    // Pure decode of registered state. A pending response freezes the CUT
    // during unload so that no captured bit is shifted out before it is stored.
    assign scan_en   = (state == SHIFT) || (state == UNLOAD);
    assign cut_ce    = (state == SHIFT) || (state == CAPT) ||
                       ((state == UNLOAD) && !rsp_valid);
    assign pat_ready = (state == IDLE) && !rsp_valid && !RST;
    assign rsp_data  = rsp;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            ld        <= '0;
            rsp       <= '0;
            last_q    <= 1'b0;
            have_rsp  <= 1'b0;
            rsp_valid <= 1'b0;
            done      <= 1'b0;
            pat_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pat_valid && pat_ready) begin
                        ld     <= pat_data;
                        last_q <= pat_last;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Shifting the new pattern in also unloads the previous
                    // capture; it only counts as a response if one was taken.
                    rsp <= rsp_nxt;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= CAPT;
                        if (have_rsp) begin
                            rsp_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CAPT: begin
                    have_rsp <= 1'b1;
                    pat_cnt  <= pat_cnt + CNT_W'(1);
                    cnt      <= '0;
                    state    <= last_q ? UNLOAD : IDLE;
                end
                UNLOAD: begin
                    if (!rsp_valid) begin
                        rsp <= rsp_nxt;
                        if (cnt == CNT_LAST) begin
                            cnt       <= '0;
                            rsp_valid <= 1'b1;
                            done      <= 1'b1;
                            have_rsp  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_ctrl
//
// Bench for scan_ctrl. Two instances: A (1 chain x 3 flops) and B (2 chains x
// 4 flops). Each drives a behavioural CUT whose capture inverts the chain
// contents. Responses from A are scored against a queue of expected words.
// Every accepted pattern p yields the response ~p, in acceptance order.
// -----------------------------------------------------------------------------
module tb_scan_ctrl;

    logic CK  = 1'b0;
    logic RST = 1'b1;
    always #5 CK = ~CK;

    // ---------------- instance A: NCHAIN=1, CHAIN_LEN=3 ----------------
    logic [2:0]  pat_data_a  = '0;
    logic        pat_valid_a = 1'b0;
    logic        pat_last_a  = 1'b0;
    logic        pat_ready_a;
    logic [2:0]  rsp_data_a;
    logic        rsp_valid_a;
    logic        rsp_ready_a;
    logic        rr_dir   = 1'b1;
    logic        rr_rnd   = 1'b0;
    logic        rnd_mode = 1'b0;
    logic        scan_en_a;
    logic [0:0]  scan_in_a;
    logic [0:0]  scan_out_a;
    logic        cut_ce_a;
    logic        done_a;
    logic [15:0] pat_cnt_a;

    assign rsp_ready_a = rnd_mode ? rr_rnd : rr_dir;

    scan_ctrl #(.NCHAIN(1), .CHAIN_LEN(3), .CNT_W(16)) u_a (
        .CK(CK), .RST(RST),
        .pat_data(pat_data_a), .pat_valid(pat_valid_a), .pat_last(pat_last_a),
        .pat_ready(pat_ready_a),
        .rsp_data(rsp_data_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .scan_en(scan_en_a), .scan_in(scan_in_a), .scan_out(scan_out_a),
        .cut_ce(cut_ce_a), .done(done_a), .pat_cnt(pat_cnt_a)
    );

    logic [2:0] cut_a = '0;
    always @(posedge CK) begin
        if (cut_ce_a) cut_a <= scan_en_a ? {cut_a[1:0], scan_in_a[0]} : ~cut_a;
    end
    assign scan_out_a = cut_a[2];

    // ---------------- instance B: NCHAIN=2, CHAIN_LEN=4 ----------------
    logic [7:0]  pat_data_b  = '0;
    logic        pat_valid_b = 1'b0;
    logic        pat_last_b  = 1'b0;
    logic        pat_ready_b;
    logic [7:0]  rsp_data_b;
    logic        rsp_valid_b;
    logic        rsp_ready_b = 1'b1;
    logic        scan_en_b;
    logic [1:0]  scan_in_b;
    logic [1:0]  scan_out_b;
    logic        cut_ce_b;
    logic        done_b;
    logic [15:0] pat_cnt_b;

    scan_ctrl #(.NCHAIN(2), .CHAIN_LEN(4), .CNT_W(16)) u_b (
        .CK(CK), .RST(RST),
        .pat_data(pat_data_b), .pat_valid(pat_valid_b), .pat_last(pat_last_b),
        .pat_ready(pat_ready_b),
        .rsp_data(rsp_data_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .scan_en(scan_en_b), .scan_in(scan_in_b), .scan_out(scan_out_b),
        .cut_ce(cut_ce_b), .done(done_b), .pat_cnt(pat_cnt_b)
    );

    logic [3:0] cut_b0 = '0;
    logic [3:0] cut_b1 = '0;
    always @(posedge CK) begin
        if (cut_ce_b) begin
            cut_b0 <= scan_en_b ? {cut_b0[2:0], scan_in_b[0]} : ~cut_b0;
            cut_b1 <= scan_en_b ? {cut_b1[2:0], scan_in_b[1]} : ~cut_b1;
        end
    end
    assign scan_out_b = {cut_b1[3], cut_b0[3]};

    // ---------------- checking infrastructure ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        n_chk++;
        n_fail++;
        $display("FAIL %s", msg);
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    typedef struct {
        logic [2:0] r;
        bit         last;
    } exp_t;

    exp_t q[$];
    exp_t e_pop;
    int   n_done_a = 0;
    int   n_sent   = 0;

    // Scoreboard for instance A, sampled mid-cycle.
    always @(negedge CK) begin
        if (!RST) begin
            if (done_a) begin
                n_done_a++;
                if (q.size() == 0) begin
                    fail_now("done_a pulsed with no response expected");
                end else begin
                    chk("done_rsp_valid", 32'(rsp_valid_a), 32'd1);
                    chk("done_on_last",   32'(q[0].last),   32'd1);
                end
            end
            if (rsp_valid_a && rsp_ready_a) begin
                if (q.size() == 0) begin
                    fail_now($sformatf("unexpected_rsp: got %0h, none expected", rsp_data_a));
                end else begin
                    e_pop = q.pop_front();
                    chk("rsp_data", 32'(rsp_data_a), 32'(e_pop.r));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CK);
            #1;
            rr_rnd = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_a(input logic [2:0] p, input bit last);
        int w;
        w = 0;
        pat_data_a  = p;
        pat_last_a  = last;
        pat_valid_a = 1'b1;
        while (!pat_ready_a && w < 200) begin
            step();
            w++;
        end
        if (!pat_ready_a) begin
            fail_now("send_a: pat_ready timeout");
            pat_valid_a = 1'b0;
            return;
        end
        q.push_back('{r: ~p, last: last});
        step();
        pat_valid_a = 1'b0;
        n_sent++;
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        while (!done_a && n < 300) begin
            step();
            n++;
        end
        if (!done_a) fail_now("wait_done_a timeout");
    endtask

    task automatic do_reset();
        pat_valid_a = 1'b0;
        pat_valid_b = 1'b0;
        RST = 1'b1;
        q.delete();
        repeat (2) @(posedge CK);
        #3 RST = 1'b0;
        @(posedge CK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected per-cycle outputs of A for a single final pattern 3'b110,
    // starting right after the handshake edge.
    typedef struct {
        logic en;
        logic si;
        logic ce;
        logic rv;
        logic dn;
    } cyc_t;

    cyc_t       tv [8];
    logic [1:0] b_si [4];

    initial begin
        int n;
        int w;
        int runs;

        tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        b_si[0] = 2'b10;
        b_si[1] = 2'b01;
        b_si[2] = 2'b10;
        b_si[3] = 2'b01;

        // ---- reset asserted before any clock edge ----
        #2;
        chk("rst_scan_en",   32'(scan_en_a),   32'd0);
        chk("rst_scan_in",   32'(scan_in_a),   32'd0);
        chk("rst_cut_ce",    32'(cut_ce_a),    32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("rst_done",      32'(done_a),      32'd0);
        chk("rst_pat_cnt",   32'(pat_cnt_a),   32'd0);
        chk("rst_rsp_data",  32'(rsp_data_a),  32'd0);
        chk("rst_pat_ready", 32'(pat_ready_a), 32'd0);
        chk("rst_b_rsp",     32'(rsp_data_b),  32'd0);
        @(posedge CK);
        #3 RST = 1'b0;
        #1;
        chk("rel_pat_ready", 32'(pat_ready_a), 32'd1);
        chk("rel_cut_ce",    32'(cut_ce_a),    32'd0);
        step();

        // ---- single final pattern 3'b110 ----
        rr_dir = 1'b1;
        send_a(3'b110, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_c%0d_scan_en", i),   32'(scan_en_a),    32'(tv[i].en));
            chk($sformatf("t2_c%0d_scan_in", i),   32'(scan_in_a),    32'(tv[i].si));
            chk($sformatf("t2_c%0d_cut_ce", i),    32'(cut_ce_a),     32'(tv[i].ce));
            chk($sformatf("t2_c%0d_rsp_valid", i), 32'(rsp_valid_a),  32'(tv[i].rv));
            chk($sformatf("t2_c%0d_done", i),      32'(done_a),       32'(tv[i].dn));
            if (i < 7) step();
        end
        chk("t2_rsp_data", 32'(rsp_data_a), 32'h1);
        chk("t2_pat_cnt",  32'(pat_cnt_a),  32'd1);
        step();

        // ---- back-to-back 3'b101 then 3'b011 (final) ----
        do_reset();
        send_a(3'b101, 1'b0);
        send_a(3'b011, 1'b1);
        step();
        step();
        chk("t3_rsp_valid_early", 32'(rsp_valid_a), 32'd0);
        step();
        chk("t3_rsp_valid_mid", 32'(rsp_valid_a), 32'd1);
        chk("t3_rsp_mid",       32'(rsp_data_a),  32'h2);
        wait_done_a(n);
        chk("t3_final_latency", 32'(n),          32'd4);
        chk("t3_rsp_final",     32'(rsp_data_a), 32'h4);
        chk("t3_pat_cnt",       32'(pat_cnt_a),  32'd2);
        step();

        // ---- backpressure at unload entry ----
        do_reset();
        rr_dir = 1'b0;
        send_a(3'b110, 1'b0);
        send_a(3'b001, 1'b1);
        repeat (3) step();
        chk("t4_rsp_valid", 32'(rsp_valid_a), 32'd1);
        chk("t4_rsp_mid",   32'(rsp_data_a),  32'h1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_stall%0d_cut_ce", i),  32'(cut_ce_a),   32'd0);
            chk($sformatf("t4_stall%0d_scan_en", i), 32'(scan_en_a),  32'd1);
            chk($sformatf("t4_stall%0d_rsp", i),     32'(rsp_data_a), 32'h1);
            step();
        end
        rr_dir = 1'b1;
        step();
        chk("t4_after_hs_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("t4_after_hs_cut_ce",    32'(cut_ce_a),    32'd1);
        wait_done_a(n);
        chk("t4_resume_latency", 32'(n),          32'd3);
        chk("t4_rsp_final",      32'(rsp_data_a), 32'h6);
        chk("t4_pat_cnt",        32'(pat_cnt_a),  32'd2);
        step();

        // ---- randomized runs against the scoreboard ----
        do_reset();
        n_sent   = 0;
        n_done_a = 0;
        runs     = 10;
        rnd_mode = 1'b1;
        for (int r = 0; r < runs; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) step();
                send_a(3'($urandom_range(0, 7)), (i == n - 1));
            end
        end
        w = 0;
        while (q.size() != 0 && w < 1000) begin
            step();
            w++;
        end
        chk("rnd_queue_drained", 32'(q.size()),  32'd0);
        chk("rnd_pat_cnt",       32'(pat_cnt_a), 32'(n_sent));
        chk("rnd_done_count",    32'(n_done_a),  32'(runs));
        rnd_mode = 1'b0;
        rr_dir   = 1'b1;
        step();

        // ---- reset during shift cycle 1 ----
        do_reset();
        send_a(3'b110, 1'b1);
        step();
        chk("t6_in_shift", 32'(scan_en_a), 32'd1);
        #2 RST = 1'b1;
        q.delete();
        #1;
        chk("t6_scan_en",   32'(scan_en_a),   32'd0);
        chk("t6_cut_ce",    32'(cut_ce_a),    32'd0);
        chk("t6_scan_in",   32'(scan_in_a),   32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("t6_done",      32'(done_a),      32'd0);
        chk("t6_pat_cnt",   32'(pat_cnt_a),   32'd0);
        #2 RST = 1'b0;
        step();
        send_a(3'b011, 1'b1);
        wait_done_a(n);
        chk("t6_latency", 32'(n),          32'd7);
        chk("t6_rsp",     32'(rsp_data_a), 32'h4);
        chk("t6_pat_cnt", 32'(pat_cnt_a),  32'd1);
        step();

        // ---- two chains of four: {4'hA, 4'h5} ----
        pat_data_b  = 8'hA5;
        pat_last_b  = 1'b1;
        pat_valid_b = 1'b1;
        w = 0;
        while (!pat_ready_b && w < 200) begin
            step();
            w++;
        end
        if (!pat_ready_b) fail_now("b: pat_ready timeout");
        step();
        pat_valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_c%0d_scan_in", i), 32'(scan_in_b), 32'(b_si[i]));
            chk($sformatf("b_c%0d_scan_en", i), 32'(scan_en_b), 32'd1);
            step();
        end
        n = 0;
        while (!done_b && n < 300) begin
            step();
            n++;
        end
        if (!done_b) fail_now("b: done timeout");
        chk("b_latency",   32'(n),           32'd5);
        chk("b_rsp_valid", 32'(rsp_valid_b), 32'd1);
        chk("b_rsp",       32'(rsp_data_b),  32'h5A);
        chk("b_pat_cnt",   32'(pat_cnt_b),   32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
